// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the RTC write scheduler.
//   - state_t: scheduler state encoding (IDLE/ISSUE/WAIT/DONE)
//   - DEF_TO_CYCLES: default per-byte timeout in clocks
//   - RTC register address constants shared with the write engine
package rtc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int DEF_TO_CYCLES = 255;

  // Clock-transfer command and the base addresses of the time, date and
  // timer register groups inside the RTC.
  localparam logic [7:0] RTC_CMD_CLK_XFER   = 8'hF0;
  localparam logic [7:0] RTC_TIME_BASE      = 8'h21;
  localparam logic [7:0] RTC_DATE_BASE      = 8'h24;
  localparam logic [7:0] RTC_TIMER_BASE     = 8'h41;

endpackage

// File: rtl/rtc_write_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
// Ports:
//   req   in  NREQ  request vector
//   ptr   in  PW    index with highest priority this round
//   grant out NREQ  one-hot grant (all zero when nothing requested)
//   valid out 1     at least one request present
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  // Pick the requester with the smallest circular distance from ptr.
  always_comb begin
    int best_d;
    int sel;
    int d;
    best_d = NREQ;
    sel    = 0;
    d      = 0;
    valid  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        d = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NREQ - int'(ptr));
        if (d < best_d) begin
          best_d = d;
          sel    = i;
        end
        valid = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = valid && (sel == i);
    end
  end

endmodule

// File: rtl/rtc_write_sched.sv
// rtc_write_sched: shares one RTC register-write engine among NREQ
// requesters. Each granted requester gets a burst of NBYTES writes to
// consecutive addresses starting at its base address, then a one-cycle ack.
// Optional feature: define RTC_WR_TIMEOUT_EN to abort a burst when the
// engine does not answer within TO_CYCLES clocks; err then pulses with ack.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   req         per-requester level request, held until ack
//   base_dir    base address, requester i at [i*8 +: 8]
//   datos       payload, byte k of requester i at [(i*NBYTES+k)*8 +: 8]
//   wr_done     completion pulse from the write engine
//   iniciar     start pulse to the write engine
//   dir, dato   address and data to the write engine
//   ack         one-cycle pulse to the served requester
//   err         timeout flag, pulses with ack
//   busy        high from grant through the DONE cycle
module rtc_write_sched
  import rtc_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int NBYTES    = 3,
  parameter int TO_CYCLES = DEF_TO_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*8-1:0]        base_dir,
  input  logic [NREQ*NBYTES*8-1:0] datos,
  input  logic                     wr_done,
  output logic                     iniciar,
  output logic [7:0]               dir,
  output logic [7:0]               dato,
  output logic [NREQ-1:0]          ack,
  output logic                     err,
  output logic                     busy
);

  localparam int PW = $clog2(NREQ);
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t                  state;
  logic [PW-1:0]           g;
  logic [PW-1:0]           ptr;
  logic [KW-1:0]           k;
  logic [7:0]              base_q;
  logic [NBYTES*8-1:0]     data_q;

  logic [NREQ-1:0]         grant;
  logic                    grant_valid;
  logic [PW-1:0]           grant_idx;

`ifdef RTC_WR_TIMEOUT_EN
  localparam int CW = ($clog2(TO_CYCLES + 1) > 8) ? $clog2(TO_CYCLES + 1) : 8;
  logic [CW-1:0]           to_cnt;
  logic                    to_hit;
`endif

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .valid (grant_valid)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = PW'(i);
    end
  end

  // Scheduler FSM. The granted requester's address and payload are copied
  // at grant time so the requester may change or drop its inputs mid-burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      g       <= '0;
      ptr     <= '0;
      k       <= '0;
      base_q  <= '0;
      data_q  <= '0;
      iniciar <= 1'b0;
      dir     <= '0;
      dato    <= '0;
      ack     <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
`ifdef RTC_WR_TIMEOUT_EN
      to_cnt  <= '0;
      to_hit  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          err <= 1'b0;
          if (grant_valid) begin
            g      <= grant_idx;
            base_q <= base_dir[int'(grant_idx)*8 +: 8];
            data_q <= datos[int'(grant_idx)*NBYTES*8 +: NBYTES*8];
            k      <= '0;
            busy   <= 1'b1;
            state  <= ISSUE;
`ifdef RTC_WR_TIMEOUT_EN
            to_hit <= 1'b0;
`endif
          end
        end

        ISSUE: begin
          iniciar <= 1'b1;
          dir     <= base_q + 8'(k);
          dato    <= data_q[int'(k)*8 +: 8];
          state   <= WAIT;
`ifdef RTC_WR_TIMEOUT_EN
          to_cnt  <= '0;
`endif
        end

        WAIT: begin
          iniciar <= 1'b0;
          if (wr_done) begin
            if (k == KW'(NBYTES - 1)) begin
              state <= DONE;
            end else begin
              k     <= k + 1'b1;
              state <= ISSUE;
            end
          end
`ifdef RTC_WR_TIMEOUT_EN
          // Engine silent too long: abandon the remaining bytes.
          else if (to_cnt == CW'(TO_CYCLES - 1)) begin
            to_hit <= 1'b1;
            state  <= DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end

        DONE: begin
          ack   <= {{(NREQ-1){1'b0}}, 1'b1} << g;
`ifdef RTC_WR_TIMEOUT_EN
          err   <= to_hit;
`else
          // Without the timeout there is no error source; TO_CYCLES is
          // always at least 1, so this is constant zero.
          err   <= (TO_CYCLES < 1);
`endif
          busy  <= 1'b0;
          ptr   <= (g == PW'(NREQ - 1)) ? '0 : g + 1'b1;
          dir   <= '0;
          dato  <= '0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_write_sched.sv
// tb_rtc_write_sched: scoreboard bench for rtc_write_sched (NREQ=3,
// NBYTES=3, TO_CYCLES=10). Expected engine writes and acks are queued by
// the stimulus; a monitor pops and compares when iniciar or ack appears.
// A small engine model answers each write with wr_done after a fixed delay.
module tb_rtc_write_sched;

  localparam int NREQ   = 3;
  localparam int NBYTES = 3;
  localparam int TO     = 10;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] v;
  } wr_t;

  typedef struct packed {
    logic [NREQ-1:0] a;
    logic            e;
  } ack_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NREQ-1:0]          req;
  logic [NREQ*8-1:0]        base_dir;
  logic [NREQ*NBYTES*8-1:0] datos;
  logic                     wr_done;
  logic                     iniciar;
  logic [7:0]               dir;
  logic [7:0]               dato;
  logic [NREQ-1:0]          ack;
  logic                     err;
  logic                     busy;

  wr_t  wq[$];
  ack_t aq[$];

  int n_compared   = 0;
  int n_mismatched = 0;
  int writes_seen  = 0;
  int stall_after  = -1;
  int eng_delay    = 2;
  int eng_cnt      = 0;
  bit eng_pending  = 0;

  rtc_write_sched #(.NREQ(NREQ), .NBYTES(NBYTES), .TO_CYCLES(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .base_dir (base_dir),
    .datos    (datos),
    .wr_done  (wr_done),
    .iniciar  (iniciar),
    .dir      (dir),
    .dato     (dato),
    .ack      (ack),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic setRequester(input int i, input logic [7:0] base,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2);
    base_dir[i*8 +: 8]          = base;
    datos[(i*NBYTES+0)*8 +: 8]  = b0;
    datos[(i*NBYTES+1)*8 +: 8]  = b1;
    datos[(i*NBYTES+2)*8 +: 8]  = b2;
  endtask

  task automatic expectBurst(input logic [7:0] base, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2,
                             input logic [NREQ-1:0] a);
    wr_t w;
    ack_t x;
    w.d = base;      w.v = b0; wq.push_back(w);
    w.d = base + 1;  w.v = b1; wq.push_back(w);
    w.d = base + 2;  w.v = b2; wq.push_back(w);
    x.a = a; x.e = 1'b0; aq.push_back(x);
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    stall_after = -1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int max_cycles);
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (!busy && ack == '0 && wq.size() == 0 && aq.size() == 0) return;
    end
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: timed out, busy=%0b pending writes=%0d acks=%0d",
             name, busy, wq.size(), aq.size());
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r);
    @(negedge clk);
    req = r;
  endtask

  // Engine model, requester ack handling and scoreboard monitor.
  always @(posedge clk) begin
    #1;
    wr_done = 1'b0;
    if (reset) begin
      eng_pending = 0;
    end else if (eng_pending) begin
      if (eng_cnt == 0) begin
        wr_done     = 1'b1;
        eng_pending = 0;
      end else begin
        eng_cnt--;
      end
    end
    if (!reset && iniciar) begin
      writes_seen++;
      if (wq.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_write: got dir=%h dato=%h, want none",
                 dir, dato);
      end else begin
        wr_t w;
        w = wq.pop_front();
        checkOutput("write_dir", 32'(dir), 32'(w.d));
        checkOutput("write_dato", 32'(dato), 32'(w.v));
      end
      if (writes_seen != stall_after) begin
        eng_pending = 1;
        eng_cnt     = eng_delay;
      end
    end
    if (!reset && ack != '0) begin
      if (aq.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_ack: got %b, want none", ack);
      end else begin
        ack_t x;
        x = aq.pop_front();
        checkOutput("ack", 32'(ack), 32'(x.a));
        checkOutput("ack_err", 32'(err), 32'(x.e));
        checkOutput("busy_at_ack", 32'(busy), 32'(0));
      end
      req = req & ~ack;
    end
  end

  initial begin
    int start;
    reset    = 1'b1;
    req      = '0;
    base_dir = '0;
    datos    = '0;
    wr_done  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_iniciar", 32'(iniciar), 32'(0));
    checkOutput("reset_dir", 32'(dir), 32'(0));
    checkOutput("reset_dato", 32'(dato), 32'(0));
    checkOutput("reset_ack", 32'(ack), 32'(0));
    checkOutput("reset_err", 32'(err), 32'(0));
    checkOutput("reset_busy", 32'(busy), 32'(0));
    reset = 1'b0;

    // Single burst with latency checks.
    $display("[TB] single burst");
    setRequester(0, 8'h21, 8'h30, 8'h45, 8'h12);
    expectBurst(8'h21, 8'h30, 8'h45, 8'h12, 3'b001);
    applyStimulus(3'b001);
    @(negedge clk);
    checkOutput("grant_busy", 32'(busy), 32'(1));
    checkOutput("grant_iniciar", 32'(iniciar), 32'(0));
    @(negedge clk);
    checkOutput("issue_iniciar", 32'(iniciar), 32'(1));
    @(negedge clk);
    checkOutput("wait_iniciar", 32'(iniciar), 32'(0));
    checkOutput("wait_dir_held", 32'(dir), 32'(8'h21));
    waitIdle("single_burst", 200);
    checkOutput("done_dir_clear", 32'(dir), 32'(0));

    // Contention from pointer 0, with requester 1 wrapping its address.
    $display("[TB] contention and address wrap");
    applyReset();
    setRequester(1, 8'hFE, 8'h11, 8'h22, 8'h33);
    setRequester(2, 8'h41, 8'h07, 8'h08, 8'h09);
    expectBurst(8'h21, 8'h30, 8'h45, 8'h12, 3'b001);
    expectBurst(8'hFE, 8'h11, 8'h22, 8'h33, 3'b010);
    expectBurst(8'h41, 8'h07, 8'h08, 8'h09, 3'b100);
    expectBurst(8'h21, 8'h30, 8'h45, 8'h12, 3'b001);
    applyStimulus(3'b111);
    for (int c = 0; c < 200 && req[0]; c++) @(negedge clk);
    req[0] = 1'b1;
    waitIdle("contention", 600);

    // Payload snapshot: inputs of the granted requester change mid-burst.
    $display("[TB] payload snapshot");
    setRequester(0, 8'h30, 8'hAA, 8'hBB, 8'hCC);
    expectBurst(8'h30, 8'hAA, 8'hBB, 8'hCC, 3'b001);
    applyStimulus(3'b001);
    @(negedge clk);
    setRequester(0, 8'h00, 8'h00, 8'h00, 8'h00);
    req[0] = 1'b0;
    waitIdle("snapshot", 200);

    // Reset while waiting on the second byte, then restart from byte 0.
    $display("[TB] reset mid-burst");
    setRequester(0, 8'h10, 8'hA1, 8'hA2, 8'hA3);
    start       = writes_seen;
    stall_after = start + 2;
    begin
      wr_t w;
      w.d = 8'h10; w.v = 8'hA1; wq.push_back(w);
      w.d = 8'h11; w.v = 8'hA2; wq.push_back(w);
    end
    applyStimulus(3'b001);
    for (int c = 0; c < 200 && writes_seen < start + 2; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("stalled_busy", 32'(busy), 32'(1));
    reset       = 1'b1;
    stall_after = -1;
    @(negedge clk);
    checkOutput("midreset_iniciar", 32'(iniciar), 32'(0));
    checkOutput("midreset_dir", 32'(dir), 32'(0));
    checkOutput("midreset_ack", 32'(ack), 32'(0));
    checkOutput("midreset_busy", 32'(busy), 32'(0));
    expectBurst(8'h10, 8'hA1, 8'hA2, 8'hA3, 3'b001);
    reset = 1'b0;
    waitIdle("restart_after_reset", 200);

    // Engine never answers.
    $display("[TB] engine stall");
    setRequester(2, 8'h41, 8'h01, 8'h02, 8'h03);
    start       = writes_seen;
    stall_after = start + 1;
    begin
      wr_t w;
      w.d = 8'h41; w.v = 8'h01; wq.push_back(w);
    end
`ifdef RTC_WR_TIMEOUT_EN
    begin
      ack_t x;
      x.a = 3'b100; x.e = 1'b1; aq.push_back(x);
    end
    applyStimulus(3'b100);
    waitIdle("timeout_abort", 200);
    repeat (5) @(negedge clk);
    checkOutput("timeout_writes", 32'(writes_seen), 32'(start + 1));
    stall_after = -1;
`else
    applyStimulus(3'b100);
    repeat (40) @(negedge clk);
    checkOutput("stall_busy", 32'(busy), 32'(1));
    checkOutput("stall_writes", 32'(writes_seen), 32'(start + 1));
    req = '0;
    applyReset();
`endif

    @(negedge clk);
    checkOutput("writes_left", 32'(wq.size()), 32'(0));
    checkOutput("acks_left", 32'(aq.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/rtc_write_sched.md
Name: rtc_write_sched

Overview:
Scheduler that shares the single RTC register-write engine among NREQ requesters, such as time-set, date-set and timer-set logic.
- Each requester asks for a burst of NBYTES writes to consecutive RTC addresses.
- The block arbitrates round-robin between requesters.
- It sequences each byte through the engine's start/finish handshake (iniciar in, final out on the engine side).
- It acknowledges the requester when the burst is complete.

Parameters:
NREQ, 3, number of requesters (2..8)
NBYTES, 3, bytes per burst (1..8)
TO_CYCLES, 255, per-byte timeout in clocks; used only with RTC_WR_TIMEOUT_EN

Ports:
clk  in  1  system clock
reset  in  1  reset
req  in  NREQ  per-requester level request; held until ack
base_dir  in  NREQ*8  base RTC address; requester i at [i*8 +: 8]
datos  in  NREQ*NBYTES*8  payload; byte k of requester i at [(i*NBYTES+k)*8 +: 8]
wr_done  in  1  one-cycle completion pulse from the write engine
iniciar  out  1  one-cycle start pulse to the write engine
dir  out  8  address to the write engine
dato  out  8  data to the write engine
ack  out  NREQ  one-cycle pulse to the served requester
err  out  1  timeout flag, pulses with ack
busy  out  1  high from grant until the DONE cycle inclusive

Behaviour:
Interface:
- One clock, clk. Reset is synchronous and active-high, port reset.
- All outputs are registered.

Reset:
- iniciar=0, dir=0, dato=0, ack=0, err=0, busy=0.
- state=IDLE, byte index k=0, round-robin pointer=0, so requester 0 has first priority.
- A reset mid-burst aborts the burst silently: no ack is issued, and pending requesters are re-arbitrated afterwards.

States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req bit is high, grant the first set bit at or after the pointer, wrapping modulo NREQ.
  - At that edge: latch grant index g, snapshot base_dir[g] and datos[g], set k=0, busy=1, go to ISSUE.
  - Later changes on the inputs of g do not affect the burst.
- ISSUE (one cycle): iniciar=1, dir=base+k (8-bit add, wraps 0xFF->0x00), dato=byte k. Go to WAIT.
- WAIT: iniciar=0; dir and dato are held stable.
  - On wr_done: if k==NBYTES-1 go to DONE; otherwise k=k+1 and go to ISSUE.
- DONE (one cycle): ack[g]=1, busy=0, pointer=(g+1) mod NREQ, clear dir and dato to 0, go to IDLE.
  - This guarantees one idle cycle between bursts so the engine returns to its idle state.

Latency:
- req sampled at edge N in IDLE: iniciar is high between edges N+1 and N+2.
- Last wr_done at edge M: ack is high between edges M+1 and M+2.

Boundary conditions:
- wr_done seen in IDLE, ISSUE or DONE: ignored.
- wr_done and a new req in the same cycle: no effect beyond the normal WAIT transition.
- req[g] dropped mid-burst: the burst still completes and ack[g] still pulses.
- req arriving during DONE: granted at the following IDLE edge.
- Several req bits set at once: round-robin order strictly.
- A requester never gets two consecutive bursts while another requester is waiting.

Optional Feature:
Macro RTC_WR_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum counter clears on entry to WAIT and increments each cycle in WAIT.
  - If it reaches TO_CYCLES before wr_done: skip the remaining bytes and go to DONE.
  - In DONE, err=1 together with ack[g].
- Not defined: no counter; WAIT waits indefinitely and err is tied to 0.

Decomposition:
- Package rtc_pkg:
  - state encoding localparams (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, DONE=2'b11)
  - default TO_CYCLES
  - RTC register address constants shared with the engine (clock-transfer command 8'hF0 and the time/date base addresses)
- Sub-module rr_arbiter:
  - purely combinational round-robin grant from req and pointer
  - outputs a one-hot grant vector and a valid flag
  - parameterised by NREQ

Test Plan:
1. Single burst: req=3'b001, base_dir[0]=8'h21, bytes 8'h30/8'h45/8'h12 -> iniciar pulses with (21,30),(22,45),(23,12), each after wr_done; then ack=3'b001 one cycle; busy drops.
2. Contention: req=3'b111 held, pointer=0 -> bursts served in order 0,1,2, then 0 again; exactly one idle cycle between bursts.
3. Address wrap: base_dir[1]=8'hFE, NBYTES=3 -> dir sequence FE, FF, 00.
4. Payload snapshot: change datos[0] and drop req[0] after grant -> original bytes written and ack[0] still pulses.
5. Reset in WAIT after the second byte -> all outputs 0 next cycle, no ack; the re-asserted req restarts from byte 0.
6. With RTC_WR_TIMEOUT_EN, TO_CYCLES=10, wr_done withheld -> after 10 WAIT cycles ack and err pulse together and the remaining bytes are not issued; without the macro busy stays high indefinitely.
